hex_display_scheduler: RTL and testbench



---
 rtl/hex_display_scheduler.sv | 135 +++++++++++++
 tb/tb_hex_display_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scheduler.sv
// Round-robin display scheduler: shares the six HEX digits between N_REQ sources
// with a minimum hold time, early rotation on next_pulse, and fully registered outputs.
module hex_display_scheduler #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset_N,
    input  logic [N_REQ-1:0]      req,
    input  logic [24*N_REQ-1:0]   data,
    input  logic                  next_pulse,
    output logic [N_REQ-1:0]      grant,
    output logic [23:0]           disp_value,
    output logic                  blank
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_r, state_nx;
    logic [IW-1:0]   g_r, g_nx;
    logic [IW-1:0]   lp_r, lp_nx;
    logic [CW-1:0]   cnt_r, cnt_nx;
    logic [N_REQ-1:0] grant_r, grant_nx;
    logic [23:0]     disp_r;
    logic            blank_r;
    logic [IW:0]     search_s;
    logic            hit_s;
    logic [IW-1:0]   sel_s;
    logic            take_s;

    // Returns {hit, index}: first requester after 'last', optionally skipping 'own'.
    function automatic logic [IW:0] rr_search(
        input logic [N_REQ-1:0] r,
        input logic [IW-1:0]    last,
        input logic [IW-1:0]    own,
        input logic             excl
    );
        logic          hit;
        logic [IW-1:0] sel;
        int            idx;
        hit = 1'b0;
        sel = {IW{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!hit && r[idx] && !(excl && (IW'(idx) == own))) begin
                hit = 1'b1;
                sel = IW'(idx);
            end else begin
                hit = hit;
            end
        end
        return {hit, sel};
    endfunction

    // Next-state logic: withdrawal first, then next_pulse/expiry rotation, else count down.
    always_comb begin
        search_s = rr_search(req, lp_r, g_r, state_r == ST_HOLD);
        hit_s    = search_s[IW];
        sel_s    = search_s[IW-1:0];
        state_nx = state_r;
        g_nx     = g_r;
        lp_nx    = lp_r;
        cnt_nx   = cnt_r;
        take_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) take_s = 1'b1;
                else       state_nx = ST_IDLE;
            end
            ST_HOLD: begin
                if (!req[g_r]) begin
                    if (hit_s) take_s = 1'b1;
                    else       state_nx = ST_IDLE;
                end else if ((next_pulse || (cnt_r == {CW{1'b0}})) && hit_s) begin
                    take_s = 1'b1;
                end else if (cnt_r != {CW{1'b0}}) begin
                    cnt_nx = cnt_r - CW'(1);
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (take_s) begin
            state_nx = ST_HOLD;
            g_nx     = sel_s;
            lp_nx    = sel_s;
            cnt_nx   = CW'(HOLD_CYCLES - 1);
        end else begin
            g_nx = g_nx;
        end
        if (state_nx == ST_HOLD) grant_nx = {{(N_REQ-1){1'b0}}, 1'b1} << g_nx;
        else                     grant_nx = {N_REQ{1'b0}};
    end

    // Arbitration state registers; lp resets to the top index so source 0 wins first.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state_r <= ST_IDLE;
            g_r     <= {IW{1'b0}};
            lp_r    <= IW'(N_REQ - 1);
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx;
            g_r     <= g_nx;
            lp_r    <= lp_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Output registers; the display tracks the next owner's live data and freezes while idle.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            grant_r <= {N_REQ{1'b0}};
            blank_r <= 1'b1;
            disp_r  <= 24'h000000;
        end else begin
            grant_r <= grant_nx;
            blank_r <= (state_nx != ST_HOLD);
            if (state_nx == ST_HOLD) disp_r <= data[24*g_nx +: 24];
            else                     disp_r <= disp_r;
        end
    end

    assign grant      = grant_r;
    assign blank      = blank_r;
    assign disp_value = disp_r;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler: a behavioural owner/hold-time model
// pushes expected outputs each edge, a monitor pops and compares on the falling edge.
module tb_hex_display_scheduler;

    localparam int N  = 4;
    localparam int HC = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [24*N-1:0] data;
    logic          next_pulse;
    logic [N-1:0]  grant;
    logic [23:0]   disp_value;
    logic          blank;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         blank;
        logic [23:0]  disp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: who owns the display, who owned it last, how long it has been held.
    int          m_owner;
    int          m_last;
    int          m_held;
    logic [23:0] m_disp;

    hex_display_scheduler #(.N_REQ(N), .HOLD_CYCLES(HC)) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .req        (req),
        .data       (data),
        .next_pulse (next_pulse),
        .grant      (grant),
        .disp_value (disp_value),
        .blank      (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int find_next(input int last, input logic [N-1:0] r, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    // Reference model: one step per rising edge, expected outputs queued for the monitor.
    always @(posedge clk) begin
        exp_t e;
        int   f;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_held  = 0;
            m_disp  = 24'h000000;
        end else if (m_owner < 0) begin
            f = find_next(m_last, req, -1);
            if (f >= 0) begin
                m_owner = f; m_last = f; m_held = 1;
            end
        end else begin
            f = find_next(m_last, req, m_owner);
            if (!req[m_owner]) begin
                m_owner = f;
                if (f >= 0) begin m_last = f; m_held = 1; end
            end else if ((next_pulse || m_held >= HC) && f >= 0) begin
                m_owner = f; m_last = f; m_held = 1;
            end else begin
                m_held = m_held + 1;
            end
        end
        if (m_owner >= 0) m_disp = data[24*m_owner +: 24];
        e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.blank = (m_owner < 0);
        e.disp  = m_disp;
        exp_q.push_back(e);
    end

    // Monitor: compare registered outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("blank", 32'(blank), 32'(e.blank));
            check("disp_value", 32'(disp_value), 32'(e.disp));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_blank"}, 32'(blank), 32'h1);
        check({tag, "_disp"},  32'(disp_value), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 4'b1111;
        data       = '0;
        next_pulse = 1'b0;
        m_owner    = -1;
        m_last     = N - 1;
        m_held     = 0;
        m_disp     = 24'h000000;
        cyc(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc(3);

        // Single source with live data change
        req = 4'b0000; cyc(1);
        req = 4'b0010; data[24*1 +: 24] = 24'h123456; cyc(22);
        data[24*1 +: 24] = 24'hABCDEF; cyc(3);

        // Round robin between sources 0 and 2
        req = 4'b0000; data[24*0 +: 24] = 24'h000A0A; data[24*2 +: 24] = 24'h0C0C0C; cyc(1);
        req = 4'b0101; cyc(20);

        // Withdrawal of owner, then of the remaining source
        req = 4'b0000; cyc(2);
        req = 4'b0101; cyc(2);
        req = 4'b0100; cyc(3);
        req = 4'b0000; cyc(3);

        // Saturation, late arrival, and ignored next_pulse
        req = 4'b0001; cyc(10);
        req = 4'b1001; data[24*3 +: 24] = 24'h333333; cyc(2);
        req = 4'b1000; cyc(2);
        next_pulse = 1'b1; cyc(1);
        next_pulse = 1'b0; cyc(2);
        req = 4'b1001; next_pulse = 1'b1; cyc(1);
        next_pulse = 1'b0; cyc(3);

        // Reset mid-hold: owner 2 with two counts left, reset between edges
        req = 4'b0000; cyc(1);
        req = 4'b0100; cyc(2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        cyc(2);
        req = 4'b0101;
        rst_n = 1'b1;
        cyc(3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
            next_pulse = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        next_pulse = 1'b0;
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
